fetch_stage: RTL and testbench
==============================

# fetch_stage

Instruction-fetch stage of the five-stage pipelined RV32I core. It owns the program counter, drives the word address of the combinational instruction ROM, and captures the returned instruction into the IF/ID pipeline register. It services stall requests from the hazard unit and redirects from EX (taken branch, `jal`, `jalr`), and recognises the halt word `32'hffff_ffff`.

## Interface
- `ADDR_W`, default 5: ROM word-address width (32 words).
- `RESET_PC`, default `32'h0000_0000`: PC value loaded on reset.
- `clk`, input, 1: rising-edge clock.
- `rst_n`, input, 1: synchronous active-low reset, sampled on the `clk` rising edge.
- `rom_addr`, output, `ADDR_W`: word address to the ROM; equals `pc[ADDR_W+1:2]`; combinational.
- `rom_instr`, input, 32: ROM data. Combinational and valid in the same cycle as `rom_addr`.
- `stall`, input, 1: hazard unit request to hold the PC and IF/ID.
- `redirect_valid`, input, 1: EX resolved a control transfer.
- `redirect_pc`, input, 32: target byte address.
- `pc`, output, 32: current fetch PC.
- `if_id_valid`, output, 1: IF/ID holds a real instruction.
- `if_id_instr`, output, 32: IF/ID instruction. A bubble carries `32'h0000_0013` (nop).
- `if_id_pc`, output, 32: byte address of `if_id_instr`.
- `halted`, output, 1: fetch is in the HALTED state.

## Operation
- States: RUN and HALTED. Reset enters RUN.
- Each rising edge applies the first matching rule below.
  1. `!rst_n`: `pc`=`RESET_PC`, `if_id_valid`=0, `if_id_instr`=nop, `if_id_pc`=0, `halted`=0.
  2. `redirect_valid`: `pc`={`redirect_pc[31:2]`,2'b00}. IF/ID is flushed to a bubble (valid=0, instr=nop, `if_id_pc` unchanged). State goes to RUN. This rule overrides `stall`, HALTED and a halt word being fetched in the same cycle.
  3. `stall`: `pc` and all IF/ID fields hold.
  4. HALTED: `pc` holds. IF/ID loads a bubble.
  5. RUN, `rom_instr`==`32'hffff_ffff`: IF/ID loads {valid=1, instr=`ffff_ffff`, pc=`pc`}. `pc` holds. State goes to HALTED.
  6. RUN otherwise: IF/ID loads {valid=1, `rom_instr`, `pc`}. `pc`=`pc`+4.
- PC arithmetic is 32-bit modulo 2^32. `pc`+4 wraps from `ffff_fffc` to 0.
- `rom_addr` aliases modulo 2^`ADDR_W` words; there is no out-of-range detection.
- A halt word fetched on a wrong path is squashed because rule 2 leaves HALTED.
- Misaligned redirect targets are silently forced to word alignment. No exception is raised.

## Timing
- ROM access is zero-cycle combinational. Latency from `pc` to IF/ID is one clock.
- Throughput is one instruction per cycle when no stall or redirect is active.
- The redirect penalty is one bubble in IF/ID from this stage. The target's instruction appears in IF/ID on the second edge after `redirect_valid`.
- `stall` is level-sensitive. N stalled cycles hold IF/ID for N edges with no duplication and no loss.
- `halted` rises on the edge that captures the halt word. It falls only on reset or on a redirect.
- Reset applied mid-operation behaves exactly as rule 1, regardless of state, `stall` or `redirect_valid`.

## Test plan
- Reset/sequence: the bench ROM returns `32'h0000_0013 | (addr<<20)`. Release reset with `RESET_PC`=0. Three edges later, `if_id_pc` steps through 0, 4, 8 with matching instr `00000013`, `00100013`, `00200013`, and `if_id_valid`=1 throughout.
- Stall: assert `stall` for 3 cycles while IF/ID holds pc=8. Both `pc`=12 and IF/ID hold for 3 edges. The next edge loads pc=12.
- Redirect: at pc=16, pulse `redirect_valid` with `redirect_pc`=`32'h0000_0051`. Next edge: `pc`=`0x50` and `if_id_valid`=0 (nop). The edge after: `if_id_pc`=`0x50`, `rom_addr` was 20.
- Redirect plus stall in the same cycle: redirect wins. Result is `pc`=target, IF/ID bubble.
- Halt: ROM word 5 = `ffff_ffff`. After pc=20 is fetched, `halted`=1, `if_id_instr`=`ffff_ffff` valid for one edge, then bubbles, and `pc` stays 20. A later redirect to 24 clears `halted` and resumes fetching at 24.
- Halt squash and reset: a halt word fetched in the same cycle as a redirect leaves `halted`=0. Deasserting `rst_n` mid-run while HALTED returns all outputs to their reset values on the next edge.

Source files
------------

// File: rtl/fetch_stage.sv
// fetch_stage: RV32I instruction fetch with PC, IF/ID register, stall, redirect and halt detection
module fetch_stage #(
   parameter int          ADDR_W   = 5,
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic              clk,
   input  logic              rst_n,
   output logic [ADDR_W-1:0] rom_addr,
   input  logic [31:0]       rom_instr,
   input  logic              stall,
   input  logic              redirect_valid,
   input  logic [31:0]       redirect_pc,
   output logic [31:0]       pc,
   output logic              if_id_valid,
   output logic [31:0]       if_id_instr,
   output logic [31:0]       if_id_pc,
   output logic              halted
);
   localparam logic [31:0] NOP  = 32'h0000_0013;
   localparam logic [31:0] HALT = 32'hffff_ffff;
   typedef enum logic {RUN, HALTED} state_t;
   state_t state;
   assign rom_addr = pc[ADDR_W+1:2];
   assign halted   = state == HALTED;
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         pc          <= RESET_PC;
         if_id_valid <= 1'b0;
         if_id_instr <= NOP;
         if_id_pc    <= 32'h0;
         state       <= RUN;
      end else if (redirect_valid) begin
         pc          <= redirect_pc & 32'hffff_fffc;
         if_id_valid <= 1'b0;
         if_id_instr <= NOP;
         state       <= RUN;
      end else if (!stall) begin
         if (state == HALTED) begin
            if_id_valid <= 1'b0;
            if_id_instr <= NOP;
         end else begin
            if_id_valid <= 1'b1;
            if_id_instr <= rom_instr;
            if_id_pc    <= pc;
            // the halt word parks the PC on itself so a redirect can resume cleanly
            if (rom_instr == HALT) state <= HALTED;
            else pc <= pc + 32'd4;
         end
      end
   end
endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: directed vector table plus randomized run against a reference model
module tb_fetch_stage;
   logic        clk = 1'b0;
   logic        rst_n, stall, redirect_valid;
   logic [31:0] redirect_pc, rom_instr, pc, if_id_instr, if_id_pc;
   logic [4:0]  rom_addr;
   logic        if_id_valid, halted;
   int checks = 0;
   int errors = 0;

   fetch_stage dut (
      .clk(clk), .rst_n(rst_n), .rom_addr(rom_addr), .rom_instr(rom_instr),
      .stall(stall), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
      .pc(pc), .if_id_valid(if_id_valid), .if_id_instr(if_id_instr),
      .if_id_pc(if_id_pc), .halted(halted)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] rom_word(input logic [4:0] a);
      return (a == 5'd5) ? 32'hffff_ffff : (32'h0000_0013 | (32'(a) << 20));
   endfunction

   assign rom_instr = rom_word(rom_addr);

   typedef struct {
      logic r, s, v;
      logic [31:0] t, pc;
      logic val;
      logic [31:0] instr, ipc;
      logic h;
   } vec_t;
   vec_t tbl[$];

   typedef struct {
      logic [31:0] pc, instr, ipc;
      logic val, h;
   } mst_t;

   function automatic mst_t ref_next(input mst_t m, input logic r, s, v, input logic [31:0] t);
      mst_t n;
      logic [31:0] w;
      n = m;
      w = rom_word(5'((m.pc / 4) % 32));
      if (!r) n = '{32'h0, 32'h13, 32'h0, 1'b0, 1'b0};
      else if (v) begin
         n.pc = t - (t % 4); n.val = 0; n.instr = 32'h13; n.h = 0;
      end else if (s) n = m;
      else if (m.h) begin
         n.val = 0; n.instr = 32'h13;
      end else begin
         n.val = 1; n.instr = w; n.ipc = m.pc;
         if (w == 32'hffff_ffff) n.h = 1;
         else n.pc = m.pc + 4;
      end
      return n;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic step(input logic r, s, v, input logic [31:0] t);
      rst_n = r; stall = s; redirect_valid = v; redirect_pc = t;
      @(posedge clk);
      #1;
   endtask

   task automatic expect_all(input string tag, input logic [31:0] epc, input logic ev,
                             input logic [31:0] ei, eipc, input logic eh);
      chk({tag, " pc"}, pc, epc);
      chk({tag, " valid"}, 32'(if_id_valid), 32'(ev));
      chk({tag, " instr"}, if_id_instr, ei);
      chk({tag, " ipc"}, if_id_pc, eipc);
      chk({tag, " halted"}, 32'(halted), 32'(eh));
      chk({tag, " rom_addr"}, 32'(rom_addr), (epc / 4) % 32);
   endtask

   task automatic add(input logic r, s, v, input logic [31:0] t, epc, input logic ev,
                      input logic [31:0] ei, eipc, input logic eh);
      tbl.push_back('{r, s, v, t, epc, ev, ei, eipc, eh});
   endtask

   initial begin
      mst_t m;
      // reset, then straight-line fetch
      add(0,0,0,0,           32'h0,  0, 32'h0000_0013, 32'h0,  0);
      add(1,0,0,0,           32'h4,  1, 32'h0000_0013, 32'h0,  0);
      add(1,0,0,0,           32'h8,  1, 32'h0010_0013, 32'h4,  0);
      add(1,0,0,0,           32'hc,  1, 32'h0020_0013, 32'h8,  0);
      // three stall cycles hold everything
      add(1,1,0,0,           32'hc,  1, 32'h0020_0013, 32'h8,  0);
      add(1,1,0,0,           32'hc,  1, 32'h0020_0013, 32'h8,  0);
      add(1,1,0,0,           32'hc,  1, 32'h0020_0013, 32'h8,  0);
      add(1,0,0,0,           32'h10, 1, 32'h0030_0013, 32'hc,  0);
      // misaligned redirect, bubble, then target
      add(1,0,1,32'h51,      32'h50, 0, 32'h0000_0013, 32'hc,  0);
      add(1,0,0,0,           32'h54, 1, 32'h0140_0013, 32'h50, 0);
      // redirect beats stall; 0x100 aliases to word 0
      add(1,1,1,32'h102,     32'h100,0, 32'h0000_0013, 32'h50, 0);
      add(1,0,0,0,           32'h104,1, 32'h0000_0013, 32'h100,0);
      add(1,1,0,0,           32'h104,1, 32'h0000_0013, 32'h100,0);
      // run into the halt word at 20
      add(1,0,1,32'h10,      32'h10, 0, 32'h0000_0013, 32'h100,0);
      add(1,0,0,0,           32'h14, 1, 32'h0040_0013, 32'h10, 0);
      add(1,0,0,0,           32'h14, 1, 32'hffff_ffff, 32'h14, 1);
      add(1,0,0,0,           32'h14, 0, 32'h0000_0013, 32'h14, 1);
      add(1,1,0,0,           32'h14, 0, 32'h0000_0013, 32'h14, 1);
      add(1,0,1,32'h18,      32'h18, 0, 32'h0000_0013, 32'h14, 0);
      add(1,0,0,0,           32'h1c, 1, 32'h0060_0013, 32'h18, 0);
      // halt word fetched together with a redirect is squashed
      add(1,0,1,32'h14,      32'h14, 0, 32'h0000_0013, 32'h18, 0);
      add(1,0,1,32'h40,      32'h40, 0, 32'h0000_0013, 32'h18, 0);
      add(1,0,0,0,           32'h44, 1, 32'h0100_0013, 32'h40, 0);
      // reset while halted, with stall and redirect also asserted
      add(1,0,1,32'h14,      32'h14, 0, 32'h0000_0013, 32'h40, 0);
      add(1,0,0,0,           32'h14, 1, 32'hffff_ffff, 32'h14, 1);
      add(0,1,1,32'h80,      32'h0,  0, 32'h0000_0013, 32'h0,  0);
      add(1,0,0,0,           32'h4,  1, 32'h0000_0013, 32'h0,  0);
      // PC wraps past the top of the address space
      add(1,0,1,32'hffff_ffff, 32'hffff_fffc, 0, 32'h0000_0013, 32'h0, 0);
      add(1,0,0,0,           32'h0,  1, 32'h01f0_0013, 32'hffff_fffc, 0);
      foreach (tbl[i]) begin
         step(tbl[i].r, tbl[i].s, tbl[i].v, tbl[i].t);
         expect_all($sformatf("vec%0d", i), tbl[i].pc, tbl[i].val, tbl[i].instr, tbl[i].ipc, tbl[i].h);
      end
      // long stall: no duplication or loss once released
      step(1,0,0,0);
      expect_all("long0", 32'h4, 1, 32'h0000_0013, 32'h0, 0);
      for (int k = 0; k < 5; k++) begin
         step(1,1,0,0);
         expect_all($sformatf("long_stall%0d", k), 32'h4, 1, 32'h0000_0013, 32'h0, 0);
      end
      step(1,0,0,0);
      expect_all("long_rel", 32'h8, 1, 32'h0010_0013, 32'h4, 0);
      // randomized run against the reference model
      step(0,0,0,0);
      m = '{32'h0, 32'h13, 32'h0, 1'b0, 1'b0};
      for (int i = 0; i < 400; i++) begin
         logic r, s, v;
         logic [31:0] t;
         r = $urandom_range(0, 39) != 0;
         s = $urandom_range(0, 3) == 0;
         v = $urandom_range(0, 7) == 0;
         t = $urandom_range(0, 1) ? 32'($urandom_range(0, 127)) : $urandom;
         m = ref_next(m, r, s, v, t);
         step(r, s, v, t);
         expect_all($sformatf("rnd%0d", i), m.pc, m.val, m.instr, m.ipc, m.h);
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end
endmodule
